dkong_dma_multi: RTL and testbench

- Parametrised multi-channel successor to the single-channel sprite DMA.
- Copies a block from a source RAM port to a destination RAM port, or fills the destination with a constant.
- Acquires the bus from the Z80 with an HRQ/HLDA handshake and releases it when the transfer ends.
- Sits beside the CPU in the top level; paced by the 3.072 MHz CPU clock-enable. Covers sprite RAM to object buffer plus extra channels (dk3b/pestplace work-RAM clears).

---
 rtl/dkong_dma_pkg.sv | 34 +++
 rtl/dkong_dma_arb.sv | 51 +++++
 rtl/dkong_dma_multi.sv | 187 ++++++++++++++++++
 tb/tb_dkong_dma_multi.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dkong_dma_pkg.sv
// dkong_dma_pkg: FSM encoding and packed-field helpers
// shared by the multi-channel DMA and its arbiter.
package dkong_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_DRAIN,
    S_FIN
  } dma_state_t;

  localparam int VEC_W = 64;
  localparam int FLD_W = 16;

  function automatic int unsigned ch_w(
    input int unsigned n
  );
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Pull field idx of width w out of a packed
  // per-channel vector (zero-extended to VEC_W).
  function automatic logic [FLD_W-1:0] get_field(
    input logic [VEC_W-1:0] vec,
    input int unsigned      idx,
    input int unsigned      w
  );
    logic [VEC_W-1:0] m;
    m = (VEC_W'(1) << w) - VEC_W'(1);
    return FLD_W'((vec >> (idx * w)) & m);
  endfunction

endpackage

// File: rtl/dkong_dma_arb.sv
// dkong_dma_arb: trigger edge capture, one pending flag per
// channel, fixed priority (lowest index) grant + index.
module dkong_dma_arb
  import dkong_dma_pkg::*;
#(
  parameter int NCH = 2,
  parameter int CHW = ch_w(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_en,
  input  logic [NCH-1:0] trig,
  input  logic [NCH-1:0] clr,
  output logic           any_pend,
  output logic [NCH-1:0] grant,
  output logic [CHW-1:0] idx
);

  logic [NCH-1:0] trig_q;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] rise;

  assign rise = clk_en ? (trig & ~trig_q) : '0;

  // An edge on an already pending channel is absorbed;
  // the clear on selection wins over such an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q <= '0;
      pend   <= '0;
    end else if (clk_en) begin
      trig_q <= trig;
      pend   <= (pend & ~clr) | (rise & ~pend);
    end
  end

  assign any_pend = |pend;

  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = CHW'(i);
      end
    end
  end

endmodule

// File: rtl/dkong_dma_multi.sv
// dkong_dma_multi: multi-channel block copy / fill DMA with
// Z80 HRQ/HLDA handshake, all state paced by I_CLK_EN.
module dkong_dma_multi
  import dkong_dma_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 10,
  parameter int DW  = 8,
  parameter int LW  = 10
) (
  input  logic              I_CLK,
  input  logic              I_RESETn,
  input  logic              I_CLK_EN,
  input  logic [NCH-1:0]    I_DMA_TRIG,
  input  logic [NCH-1:0]    I_MODE_FILL,
  input  logic [NCH*AW-1:0] I_SRC_BASE,
  input  logic [NCH*AW-1:0] I_DST_BASE,
  input  logic [NCH*LW-1:0] I_LEN,
  input  logic [DW-1:0]     I_FILL_D,
  input  logic              I_HLDA,
  input  logic [DW-1:0]     I_DMA_DS,
  output logic              O_HRQ,
  output logic [AW-1:0]     O_DMA_AS,
  output logic              O_DMA_CES,
  output logic [AW-1:0]     O_DMA_AD,
  output logic [DW-1:0]     O_DMA_DD,
  output logic              O_DMA_CED,
  output logic              O_BUSY,
  output logic [1:0]        O_ACT_CH,
  output logic [NCH-1:0]    O_DONE
);

  localparam int CHW = ch_w(NCH);

  dma_state_t state, state_n;

  logic           any_pend;
  logic [NCH-1:0] grant;
  logic [NCH-1:0] clr;
  logic [CHW-1:0] sel_idx;
  logic [CHW-1:0] ch_q;

  logic [VEC_W-1:0] src_v, dst_v, len_v;
  logic [AW-1:0]    sel_src, sel_dst;
  logic [LW-1:0]    sel_len;

  logic          mode_q;
  logic [AW-1:0] src_q, dst_q;
  logic [LW-1:0] len_q, rcnt, wcnt;
  logic          rd_vld;

  logic start, hrq, busy, ces, ced;
  logic [AW-1:0]  as_c, ad_c;
  logic [DW-1:0]  dd_c;
  logic [NCH-1:0] done_c;

  dkong_dma_arb #(
    .NCH(NCH),
    .CHW(CHW)
  ) u_arb (
    .clk     (I_CLK),
    .rst_n   (I_RESETn),
    .clk_en  (I_CLK_EN),
    .trig    (I_DMA_TRIG),
    .clr     (clr),
    .any_pend(any_pend),
    .grant   (grant),
    .idx     (sel_idx)
  );

  assign src_v = VEC_W'(I_SRC_BASE);
  assign dst_v = VEC_W'(I_DST_BASE);
  assign len_v = VEC_W'(I_LEN);

  assign sel_src = AW'(get_field(src_v, 32'(sel_idx), AW));
  assign sel_dst = AW'(get_field(dst_v, 32'(sel_idx), AW));
  assign sel_len = LW'(get_field(len_v, 32'(sel_idx), LW));

  always_ff @(posedge I_CLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state <= S_IDLE;
    end else if (I_CLK_EN) begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    clr     = '0;
    hrq     = 1'b0;
    busy    = 1'b0;
    ces     = 1'b0;
    ced     = 1'b0;
    as_c    = '0;
    ad_c    = '0;
    dd_c    = '0;
    done_c  = '0;
    unique case (state)
      S_IDLE: begin
        if (I_CLK_EN && any_pend) begin
          start = 1'b1;
          clr   = grant;
          if (sel_len == '0) state_n = S_FIN;
          else               state_n = S_REQ;
        end
      end
      S_REQ: begin
        hrq  = 1'b1;
        busy = 1'b1;
        if (I_CLK_EN && I_HLDA) state_n = S_XFER;
      end
      S_XFER: begin
        hrq  = 1'b1;
        busy = 1'b1;
        if (I_CLK_EN && I_HLDA) begin
          // Copy: write lags read by one cycle.
          ces = !mode_q && (rcnt != len_q);
          ced = mode_q || rd_vld;
          if (ces) as_c = src_q + AW'(rcnt);
          if (ced) begin
            ad_c = dst_q + AW'(wcnt);
            dd_c = mode_q ? I_FILL_D : I_DMA_DS;
            if (wcnt == len_q - 1'b1) state_n = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (I_CLK_EN && !I_HLDA) state_n = S_FIN;
      end
      S_FIN: begin
        if (I_CLK_EN) begin
          done_c[ch_q] = 1'b1;
          state_n      = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // On bus loss the read already in flight is discarded
  // and re-issued on resume: rewind read to write count.
  always_ff @(posedge I_CLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      ch_q   <= '0;
      mode_q <= 1'b0;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      rcnt   <= '0;
      wcnt   <= '0;
      rd_vld <= 1'b0;
    end else if (I_CLK_EN) begin
      if (start) begin
        ch_q   <= sel_idx;
        mode_q <= I_MODE_FILL[sel_idx];
        src_q  <= sel_src;
        dst_q  <= sel_dst;
        len_q  <= sel_len;
        rcnt   <= '0;
        wcnt   <= '0;
        rd_vld <= 1'b0;
      end else if (state == S_XFER) begin
        if (I_HLDA) begin
          rcnt   <= rcnt + LW'(ces);
          wcnt   <= wcnt + LW'(ced);
          rd_vld <= ces;
        end else begin
          rcnt   <= wcnt;
          rd_vld <= 1'b0;
        end
      end
    end
  end

  assign O_HRQ     = hrq;
  assign O_BUSY    = busy;
  assign O_DMA_CES = ces;
  assign O_DMA_AS  = as_c;
  assign O_DMA_CED = ced;
  assign O_DMA_AD  = ad_c;
  assign O_DMA_DD  = dd_c;
  assign O_DONE    = done_c;
  assign O_ACT_CH  = 2'(ch_q);

endmodule

// File: tb/tb_dkong_dma_multi.sv
// tb_dkong_dma_multi: scoreboard bench for dkong_dma_multi,
// random clock enable, HLDA responder and source RAM model.
module tb_dkong_dma_multi;

  localparam int NCH = 2;
  localparam int AW  = 10;
  localparam int DW  = 8;
  localparam int LW  = 10;
  localparam int AM  = 1 << AW;

  logic              I_CLK = 1'b0;
  logic              I_RESETn;
  logic              I_CLK_EN;
  logic [NCH-1:0]    I_DMA_TRIG;
  logic [NCH-1:0]    I_MODE_FILL;
  logic [NCH*AW-1:0] I_SRC_BASE;
  logic [NCH*AW-1:0] I_DST_BASE;
  logic [NCH*LW-1:0] I_LEN;
  logic [DW-1:0]     I_FILL_D;
  logic              I_HLDA;
  logic [DW-1:0]     I_DMA_DS;
  logic              O_HRQ;
  logic [AW-1:0]     O_DMA_AS;
  logic              O_DMA_CES;
  logic [AW-1:0]     O_DMA_AD;
  logic [DW-1:0]     O_DMA_DD;
  logic              O_DMA_CED;
  logic              O_BUSY;
  logic [1:0]        O_ACT_CH;
  logic [NCH-1:0]    O_DONE;

  dkong_dma_multi #(
    .NCH(NCH), .AW(AW), .DW(DW), .LW(LW)
  ) dut (
    .I_CLK      (I_CLK),
    .I_RESETn   (I_RESETn),
    .I_CLK_EN   (I_CLK_EN),
    .I_DMA_TRIG (I_DMA_TRIG),
    .I_MODE_FILL(I_MODE_FILL),
    .I_SRC_BASE (I_SRC_BASE),
    .I_DST_BASE (I_DST_BASE),
    .I_LEN      (I_LEN),
    .I_FILL_D   (I_FILL_D),
    .I_HLDA     (I_HLDA),
    .I_DMA_DS   (I_DMA_DS),
    .O_HRQ      (O_HRQ),
    .O_DMA_AS   (O_DMA_AS),
    .O_DMA_CES  (O_DMA_CES),
    .O_DMA_AD   (O_DMA_AD),
    .O_DMA_DD   (O_DMA_DD),
    .O_DMA_CED  (O_DMA_CED),
    .O_BUSY     (O_BUSY),
    .O_ACT_CH   (O_ACT_CH),
    .O_DONE     (O_DONE)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    int ch;
    int addr;
    int data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];

  int tests = 0;
  int errors = 0;

  int src_mem[AM];
  int cfg_src[NCH];
  int cfg_dst[NCH];
  int cfg_len[NCH];
  int cfg_fill[NCH];
  int fill_val;

  int   wr_cnt, strobe_cyc, ces_cyc, hrq_rises;
  logic hrq_prev = 1'b0;
  logic hlda_n = 1'b0;
  int   lat_cnt = 0;
  int   gap_at = 0, gap_len = 0, gap_left = 0;

  task automatic check(input string nm,
                       input longint got,
                       input longint exp);
    tests++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h",
               nm, got, exp);
    end
  endtask

  // Registered source RAM: data one enabled cycle after CES.
  always @(posedge I_CLK)
    if (I_CLK_EN && O_DMA_CES)
      I_DMA_DS <= DW'(src_mem[O_DMA_AS]);

  // Random clock enable and HLDA drive, after the edge.
  initial begin
    I_CLK_EN = 1'b0;
    I_HLDA   = 1'b0;
    forever begin
      @(posedge I_CLK);
      #1;
      I_CLK_EN = ($urandom_range(0, 3) != 0);
      I_HLDA   = hlda_n;
    end
  end

  // Monitor + bus-grant responder, sampled mid-cycle.
  always @(negedge I_CLK) begin
    wr_t e;
    int  d;
    if (I_RESETn) begin
      if (O_HRQ && !hrq_prev) hrq_rises++;
      hrq_prev = O_HRQ;
      if (O_DMA_CES || O_DMA_CED) begin
        strobe_cyc++;
        check("strobe_clk_en", I_CLK_EN, 1);
        check("strobe_hlda", I_HLDA, 1);
      end
      if (O_DMA_CES) ces_cyc++;
      if (O_DMA_CED) begin
        if (exp_wr.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL wr_extra: got write %0h=%0h, required none",
                   O_DMA_AD, O_DMA_DD);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", O_DMA_AD, e.addr);
          check("wr_data", O_DMA_DD, e.data);
          check("wr_act_ch", O_ACT_CH, e.ch);
        end
      end
      if (O_DONE != '0) begin
        if (exp_done.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL done_extra: got %0b, required none",
                   O_DONE);
        end else begin
          d = exp_done.pop_front();
          check("done_ch", O_DONE, 1 << d);
          check("done_bus_free", {O_HRQ, I_HLDA}, 0);
        end
      end
      if (I_CLK_EN) begin
        if (gap_left > 0) begin
          gap_left--;
          if (gap_left == 0) hlda_n = 1'b1;
        end else if (O_HRQ && !I_HLDA) begin
          lat_cnt++;
          if (lat_cnt >= 2) begin
            hlda_n  = 1'b1;
            lat_cnt = 0;
          end
        end else if (!O_HRQ && I_HLDA) begin
          hlda_n = 1'b0;
        end
        if (O_DMA_CED) begin
          wr_cnt++;
          if (gap_at != 0 && wr_cnt == gap_at) begin
            gap_left = gap_len;
            hlda_n   = 1'b0;
            gap_at   = 0;
          end
        end
      end
    end else begin
      hrq_prev = 1'b0;
    end
  end

  task automatic clr_counts();
    wr_cnt     = 0;
    strobe_cyc = 0;
    ces_cyc    = 0;
    hrq_rises  = 0;
  endtask

  task automatic setup(input int ch, input int fill,
                       input int src, input int dst,
                       input int len);
    cfg_src[ch]  = src % AM;
    cfg_dst[ch]  = dst % AM;
    cfg_len[ch]  = len;
    cfg_fill[ch] = fill;
    I_SRC_BASE = {AW'(cfg_src[1]), AW'(cfg_src[0])};
    I_DST_BASE = {AW'(cfg_dst[1]), AW'(cfg_dst[0])};
    I_LEN      = {LW'(cfg_len[1]), LW'(cfg_len[0])};
    I_MODE_FILL = {cfg_fill[1] != 0, cfg_fill[0] != 0};
  endtask

  task automatic wait_en();
    int c;
    c = 0;
    do begin
      @(negedge I_CLK);
      c++;
    end while (!I_CLK_EN && c < 200);
  endtask

  // Reference: lower channels run first, each writes dst+k
  // with source byte src+k (or the fill value), mod 2^AW.
  task automatic fire(input logic [NCH-1:0] m);
    wr_t e;
    for (int i = 0; i < NCH; i++) begin
      if (m[i]) begin
        for (int k = 0; k < cfg_len[i]; k++) begin
          e.ch   = i;
          e.addr = (cfg_dst[i] + k) % AM;
          e.data = (cfg_fill[i] != 0) ? fill_val
                 : src_mem[(cfg_src[i] + k) % AM];
          exp_wr.push_back(e);
        end
        exp_done.push_back(i);
      end
    end
    @(posedge I_CLK);
    #1;
    I_DMA_TRIG = m;
    wait_en();
    @(posedge I_CLK);
    #1;
    I_DMA_TRIG = '0;
    wait_en();
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int c;
    c = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0 ||
            O_BUSY) && c < maxc) begin
      @(posedge I_CLK);
      c++;
    end
    tests++;
    if (c >= maxc) begin
      errors++;
      $display("FAIL %s_timeout: got %0d writes left, required 0",
               nm, exp_wr.size());
    end
    repeat (3) @(posedge I_CLK);
    #1;
  endtask

  initial begin
    int c;
    logic [NCH-1:0] m;
    I_RESETn    = 1'b0;
    I_DMA_TRIG  = '0;
    I_MODE_FILL = '0;
    I_SRC_BASE  = '0;
    I_DST_BASE  = '0;
    I_LEN       = '0;
    I_FILL_D    = '0;
    fill_val    = 0;
    for (int i = 0; i < AM; i++) src_mem[i] = $urandom_range(0, 255);
    for (int i = 0; i < NCH; i++) setup(i, 0, 0, 0, 0);
    clr_counts();
    repeat (3) @(posedge I_CLK);
    #1;
    check("rst_outs",
          {O_HRQ, O_DMA_CES, O_DMA_CED, O_BUSY, O_DONE, O_ACT_CH}, 0);
    check("rst_addr", {O_DMA_AS, O_DMA_AD, O_DMA_DD}, 0);
    I_RESETn = 1'b1;
    repeat (2) @(posedge I_CLK);
    #1;

    // Copy ch0: 0x100 -> 0x000, 384 bytes.
    clr_counts();
    setup(0, 0, 'h100, 'h000, 'h180);
    fire(2'b01);
    wait_idle(5000, "copy0");
    check("copy0_writes", wr_cnt, 384);
    check("copy0_xfer_cycles", strobe_cyc, 385);
    check("copy0_hrq_rises", hrq_rises, 1);

    // Fill ch1 wrapping at the top of the address space.
    clr_counts();
    fill_val = 'hAA;
    I_FILL_D = 8'hAA;
    setup(1, 1, 0, 'h3F0, 'h20);
    fire(2'b10);
    wait_idle(2000, "fill1");
    check("fill1_writes", wr_cnt, 32);
    check("fill1_no_ces", ces_cyc, 0);

    // Both channels together: ch0 first, bus released between.
    clr_counts();
    setup(0, 0, $urandom_range(0, AM - 1), $urandom_range(0, AM - 1), 12);
    setup(1, 1, 0, $urandom_range(0, AM - 1), 9);
    fire(2'b11);
    wait_idle(2000, "both");
    check("both_writes", wr_cnt, 21);
    check("both_hrq_rises", hrq_rises, 2);

    // Bus lost for 5 enabled cycles at k=10.
    clr_counts();
    gap_at  = 10;
    gap_len = 5;
    setup(0, 0, $urandom_range(0, AM - 1), $urandom_range(0, AM - 1), 16);
    fire(2'b01);
    wait_idle(2000, "gap");
    check("gap_taken", gap_at, 0);
    check("gap_writes", wr_cnt, 16);

    // Zero length: done without a bus request.
    clr_counts();
    setup(0, 0, 0, 0, 0);
    fire(2'b01);
    wait_idle(500, "len0");
    check("len0_hrq_rises", hrq_rises, 0);
    check("len0_writes", wr_cnt, 0);

    // Reset at k=50, then a clean restart.
    clr_counts();
    setup(0, 0, $urandom_range(0, AM - 1), $urandom_range(0, AM - 1), 100);
    fire(2'b01);
    c = 0;
    while (wr_cnt < 50 && c < 3000) begin
      @(posedge I_CLK);
      c++;
    end
    check("rst_reached_k50", wr_cnt >= 50, 1);
    #1;
    I_RESETn = 1'b0;
    #1;
    check("midrst_outs",
          {O_HRQ, O_DMA_CES, O_DMA_CED, O_BUSY, O_DONE, O_ACT_CH}, 0);
    check("midrst_addr", {O_DMA_AS, O_DMA_AD, O_DMA_DD}, 0);
    exp_wr.delete();
    exp_done.delete();
    hlda_n   = 1'b0;
    I_HLDA   = 1'b0;
    gap_left = 0;
    lat_cnt  = 0;
    repeat (3) @(posedge I_CLK);
    #1;
    I_RESETn = 1'b1;
    repeat (2) @(posedge I_CLK);
    #1;
    clr_counts();
    setup(0, 0, $urandom_range(0, AM - 1), $urandom_range(0, AM - 1), 20);
    fire(2'b01);
    wait_idle(2000, "restart");
    check("restart_writes", wr_cnt, 20);

    // Random mix of channels, modes and lengths.
    for (int t = 0; t < 6; t++) begin
      clr_counts();
      fill_val = $urandom_range(0, 255);
      I_FILL_D = DW'(fill_val);
      for (int i = 0; i < NCH; i++)
        setup(i, $urandom_range(0, 1), $urandom_range(0, AM - 1),
              $urandom_range(0, AM - 1), $urandom_range(0, 40));
      m = NCH'($urandom_range(1, 3));
      fire(m);
      wait_idle(3000, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
